cpu_adr_idu: RTL

//  CPU address-bus latch plus 16-bit increment/decrement unit (IDU). Sits between the

---
 rtl/cpu_adr_idu.sv | 91 +++++++++
 1 files changed

// File: rtl/cpu_adr_idu.sv
// Address-bus latch and 16-bit increment/decrement unit.
// Latches one address source per M-cycle and writes adr/adr+1/adr-1 back at T3.
module cpu_adr_idu #(
    parameter logic [15:0] RESET_ADR = 16'h0000
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        ce,
    input  logic [2:0]  src_sel,
    input  logic [1:0]  idu_op,
    input  logic [2:0]  wb_dst,
    input  logic [15:0] reg_pc,
    input  logic [15:0] reg_sp,
    input  logic [15:0] reg_hl,
    input  logic [15:0] reg_bc,
    input  logic [15:0] reg_de,
    input  logic [15:0] reg_wz,
    input  logic [7:0]  lo,
    output logic [15:0] adr,
    output logic [1:0]  t_state,
    output logic        m_end,
    output logic [15:0] wb_data,
    output logic [6:0]  wb_we
);

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_PASS = 2'd1,
        OP_INC  = 2'd2,
        OP_DEC  = 2'd3
    } op_t;

    logic [1:0]  t_q;
    op_t         op_q;
    logic [2:0]  dst_q;
    logic [15:0] adr_q;
    logic [15:0] src_adr;

    always_comb begin
        src_adr = adr_q;
        case (src_sel)
            3'd0:    src_adr = reg_pc;
            3'd1:    src_adr = reg_sp;
            3'd2:    src_adr = reg_hl;
            3'd3:    src_adr = reg_bc;
            3'd4:    src_adr = reg_de;
            3'd5:    src_adr = reg_wz;
            3'd6:    src_adr = {8'hff, lo};
            default: src_adr = adr_q;
        endcase
    end

    // Sources are sampled only on the T4->T1 edge, so adr holds a full M-cycle.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            t_q   <= 2'd3;
            adr_q <= RESET_ADR;
            op_q  <= OP_NONE;
            dst_q <= 3'd0;
        end else if (ce) begin
            t_q <= t_q + 2'd1;
            if (t_q == 2'd3) begin
                adr_q <= src_adr;
                op_q  <= op_t'(idu_op);
                dst_q <= wb_dst;
            end
        end
    end

    always_comb begin
        wb_data = adr_q;
        case (op_q)
            OP_INC:  wb_data = adr_q + 16'd1;
            OP_DEC:  wb_data = adr_q - 16'd1;
            default: wb_data = adr_q;
        endcase
    end

    // nreset gates the strobe so a reset at T3 cannot leak a partial write.
    always_comb begin
        wb_we = 7'd0;
        if (nreset && ce && t_q == 2'd2 && op_q != OP_NONE
            && dst_q != 3'd0 && dst_q != 3'd7)
            wb_we[dst_q] = 1'b1;
    end

    assign adr     = adr_q;
    assign t_state = t_q;
    assign m_end   = (t_q == 2'd3);

endmodule
